// File: rtl/video_mode_pkg.sv
// Shared video-mode definitions: slot encodings, geometry constants,
// tracker FSM states and the width classification used by the linebuffer.
package video_mode_pkg;

    localparam logic [2:0] SLOT_256 = 3'd0;
    localparam logic [2:0] SLOT_360 = 3'd1;
    localparam logic [2:0] SLOT_512 = 3'd2;

    localparam logic [9:0] WIDTH_256 = 10'd256;
    localparam logic [9:0] WIDTH_360 = 10'd360;
    localparam logic [9:0] WIDTH_512 = 10'd512;
    localparam logic [9:0] LINES_224 = 10'd224;
    localparam logic [9:0] LINES_240 = 10'd240;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        CONFIRM  = 2'd1,
        LOCKED   = 2'd2
    } trk_state_e;

    typedef struct packed {
        logic [2:0] slot;
        logic       l224;
    } mode_t;

    function automatic logic [2:0] slot_of(input logic [9:0] width,
                                           input logic [9:0] thresh_w0,
                                           input logic [9:0] thresh_w1);
        if (width < thresh_w0)      return SLOT_256;
        else if (width < thresh_w1) return SLOT_360;
        else                        return SLOT_512;
    endfunction

    function automatic logic [9:0] width_of(input logic [2:0] slot);
        case (slot)
            SLOT_256: return WIDTH_256;
            SLOT_360: return WIDTH_360;
            default:  return WIDTH_512;
        endcase
    endfunction

endpackage

// File: rtl/video_geom_counter.sv
// Pixel/line counters with per-frame max-width tracking. Exposes the
// frame-closure values combinationally (including a line closed in the
// same cycle as the vsync edge) and registers them as measured_*.
module video_geom_counter (
    input  logic       clk_vid,
    input  logic       reset_n,
    input  logic       vsync_i,
    input  logic       hsync_i,
    input  logic       ce_pix_i,
    input  logic       disable_pix_i,
    output logic       frame_done_o,
    output logic [9:0] frame_max_o,
    output logic [9:0] frame_lines_o,
    output logic [9:0] measured_width_o,
    output logic [9:0] measured_lines_o
);

    localparam logic [9:0] CNT_MAX = 10'h3FF;

    logic       vsync_q, hsync_q;
    logic [9:0] pix_cnt_q, frame_max_q, line_cnt_q;
    logic [9:0] meas_w_q, meas_l_q;
    logic [9:0] frame_max_d, line_cnt_d;
    logic       hs_edge, vs_edge, pix_inc, line_close;

    assign hs_edge    = hsync_i & ~hsync_q;
    assign vs_edge    = vsync_i & ~vsync_q;
    assign pix_inc    = ce_pix_i & ~disable_pix_i;
    assign line_close = hs_edge && (pix_cnt_q != 10'd0);

    // Line closure forwarded so a coincident vsync sees the closed line.
    always_comb begin
        frame_max_d = frame_max_q;
        line_cnt_d  = line_cnt_q;
        if (line_close) begin
            if (pix_cnt_q > frame_max_q) frame_max_d = pix_cnt_q;
            if (line_cnt_q != CNT_MAX)   line_cnt_d  = line_cnt_q + 10'd1;
        end
    end

    // Edge history, counters and frame-closure capture.
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            vsync_q     <= 1'b0;
            hsync_q     <= 1'b0;
            pix_cnt_q   <= 10'd0;
            frame_max_q <= 10'd0;
            line_cnt_q  <= 10'd0;
            meas_w_q    <= 10'd0;
            meas_l_q    <= 10'd0;
        end else begin
            vsync_q <= vsync_i;
            hsync_q <= hsync_i;
            if (vs_edge) begin
                meas_w_q    <= frame_max_d;
                meas_l_q    <= line_cnt_d;
                frame_max_q <= 10'd0;
                line_cnt_q  <= 10'd0;
                pix_cnt_q   <= 10'd0;
            end else begin
                frame_max_q <= frame_max_d;
                line_cnt_q  <= line_cnt_d;
                if (hs_edge)
                    pix_cnt_q <= 10'd0;
                else if (pix_inc && pix_cnt_q != CNT_MAX)
                    pix_cnt_q <= pix_cnt_q + 10'd1;
            end
        end
    end

    assign frame_done_o     = vs_edge;
    assign frame_max_o      = frame_max_d;
    assign frame_lines_o    = line_cnt_d;
    assign measured_width_o = meas_w_q;
    assign measured_lines_o = meas_l_q;

endmodule

// File: rtl/video_mode_tracker.sv
// Debounces measured video geometry across frames and publishes a committed
// mode. Optional macro VIDEO_MODE_OVERRIDE_EN adds force_en/force_slot/
// force_224 inputs that override the visible mode while the FSM keeps tracking.
//
// state    | meaning
// UNLOCKED | no mode seen since reset
// CONFIRM  | candidate differs from committed mode, counting identical frames
// LOCKED   | committed mode matches the incoming frames
module video_mode_tracker
    import video_mode_pkg::*;
#(
    parameter logic [3:0] STABLE_FRAMES = 4'd3,
    parameter logic [9:0] THRESH_W0     = 10'd280,
    parameter logic [9:0] THRESH_W1     = 10'd380,
    parameter logic [9:0] THRESH_LINES  = 10'd231
) (
    input  logic       clk_vid,
    input  logic       reset_n,
    input  logic       vsync_in,
    input  logic       hsync_in,
    input  logic       ce_pix,
    input  logic       disable_pix,
    output logic [2:0] slot,
    output logic [9:0] expected_width,
    output logic [9:0] expected_lines,
    output logic       line_224,
    output logic       mode_valid,
    output logic       mode_change,
    output logic [9:0] measured_width,
    output logic [9:0] measured_lines
`ifdef VIDEO_MODE_OVERRIDE_EN
    ,
    input  logic       force_en,
    input  logic [2:0] force_slot,
    input  logic       force_224
`endif
);

    logic       frame_done;
    logic [9:0] frame_max, frame_lines;

    video_geom_counter u_geom (
        .clk_vid          (clk_vid),
        .reset_n          (reset_n),
        .vsync_i          (vsync_in),
        .hsync_i          (hsync_in),
        .ce_pix_i         (ce_pix),
        .disable_pix_i    (disable_pix),
        .frame_done_o     (frame_done),
        .frame_max_o      (frame_max),
        .frame_lines_o    (frame_lines),
        .measured_width_o (measured_width),
        .measured_lines_o (measured_lines)
    );

    trk_state_e state_q, state_d;
    mode_t      pend_q, pend_d, cm_q, cm_d, vis_q, vis_d, cand;
    logic [3:0] stable_q, stable_d;
    logic       cm_valid_q, cm_valid_d, vis_valid_d;
    logic       mode_valid_q, mode_change_q, mode_change_d;
    logic [9:0] exp_w_q, exp_l_q;
    logic       frame_valid, commit;

    assign cand.slot   = slot_of(frame_max, THRESH_W0, THRESH_W1);
    assign cand.l224   = frame_lines < THRESH_LINES;
    assign frame_valid = frame_done && (frame_max != 10'd0);

    // Next-state and commit decision; empty frames leave the FSM untouched.
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        stable_d = stable_q;
        commit   = 1'b0;
        if (frame_valid) begin
            case (state_q)
                UNLOCKED: begin
                    pend_d   = cand;
                    stable_d = 4'd1;
                    if (STABLE_FRAMES == 4'd1) begin
                        commit  = 1'b1;
                        state_d = LOCKED;
                    end else begin
                        state_d = CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (cand == pend_q) begin
                        stable_d = stable_q + 4'd1;
                        if (stable_d == STABLE_FRAMES) begin
                            commit  = 1'b1;
                            state_d = LOCKED;
                        end
                    end else begin
                        pend_d   = cand;
                        stable_d = 4'd1;
                    end
                end
                LOCKED: begin
                    if (cand != cm_q) begin
                        pend_d   = cand;
                        stable_d = 4'd1;
                        if (STABLE_FRAMES == 4'd1) commit  = 1'b1;
                        else                       state_d = CONFIRM;
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
    end

    // Committed mode, then the visible mode (forced or committed).
    always_comb begin
        cm_d       = commit ? cand : cm_q;
        cm_valid_d = cm_valid_q | commit;
`ifdef VIDEO_MODE_OVERRIDE_EN
        if (force_en) begin
            vis_d.slot = force_slot;
            vis_d.l224 = force_224;
        end else begin
            vis_d = cm_d;
        end
        vis_valid_d = force_en | cm_valid_d;
`else
        vis_d       = cm_d;
        vis_valid_d = cm_valid_d;
`endif
        mode_change_d = vis_valid_d && (!mode_valid_q || (vis_d != vis_q));
    end

    // FSM state register.
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= UNLOCKED;
            pend_q   <= '0;
            stable_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            stable_q <= stable_d;
        end
    end

    // Committed and visible mode registers with their width/line decode.
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            cm_q          <= '{slot: SLOT_256, l224: 1'b0};
            cm_valid_q    <= 1'b0;
            vis_q         <= '{slot: SLOT_256, l224: 1'b0};
            mode_valid_q  <= 1'b0;
            mode_change_q <= 1'b0;
            exp_w_q       <= WIDTH_256;
            exp_l_q       <= LINES_240;
        end else begin
            cm_q          <= cm_d;
            cm_valid_q    <= cm_valid_d;
            vis_q         <= vis_d;
            mode_valid_q  <= vis_valid_d;
            mode_change_q <= mode_change_d;
            exp_w_q       <= width_of(vis_d.slot);
            exp_l_q       <= vis_d.l224 ? LINES_224 : LINES_240;
        end
    end

    assign slot           = vis_q.slot;
    assign line_224       = vis_q.l224;
    assign expected_width = exp_w_q;
    assign expected_lines = exp_l_q;
    assign mode_valid     = mode_valid_q;
    assign mode_change    = mode_change_q;

endmodule

// File: tb/tb_video_mode_tracker.sv
// Directed bench for video_mode_tracker. Frames are built from one line of
// the target width followed by single-pixel lines, so line count and max
// width are exercised without full-size frames.
module tb_video_mode_tracker;

    logic       clk_vid = 1'b0;
    logic       reset_n = 1'b0;
    logic       vsync_in = 1'b0;
    logic       hsync_in = 1'b0;
    logic       ce_pix = 1'b0;
    logic       disable_pix = 1'b0;
    logic [2:0] slot;
    logic [9:0] expected_width, expected_lines, measured_width, measured_lines;
    logic       line_224, mode_valid, mode_change;
`ifdef VIDEO_MODE_OVERRIDE_EN
    logic       force_en = 1'b0;
    logic [2:0] force_slot = 3'd0;
    logic       force_224 = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int pulses = 0;

    video_mode_tracker dut (
        .clk_vid        (clk_vid),
        .reset_n        (reset_n),
        .vsync_in       (vsync_in),
        .hsync_in       (hsync_in),
        .ce_pix         (ce_pix),
        .disable_pix    (disable_pix),
        .slot           (slot),
        .expected_width (expected_width),
        .expected_lines (expected_lines),
        .line_224       (line_224),
        .mode_valid     (mode_valid),
        .mode_change    (mode_change),
        .measured_width (measured_width),
        .measured_lines (measured_lines)
`ifdef VIDEO_MODE_OVERRIDE_EN
        ,
        .force_en       (force_en),
        .force_slot     (force_slot),
        .force_224      (force_224)
`endif
    );

    always #5 clk_vid = ~clk_vid;

    always @(negedge clk_vid) if (mode_change === 1'b1) pulses++;

    task automatic tick();
        @(posedge clk_vid);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_line(input int npix, input bit blank);
        ce_pix = 1'b1;
        disable_pix = blank;
        repeat (npix) tick();
        ce_pix = 1'b0;
        disable_pix = 1'b0;
        hsync_in = 1'b1;
        tick();
        hsync_in = 1'b0;
        tick();
    endtask

    task automatic send_frame(input int width, input int lines, input bit blank = 1'b0,
                              input bit simul = 1'b0);
        send_line(width, blank);
        for (int i = 1; i < lines; i++) begin
            if (simul && i == lines - 1) begin
                ce_pix = 1'b1;
                tick();
                ce_pix = 1'b0;
                hsync_in = 1'b1;
                vsync_in = 1'b1;
                tick();
                hsync_in = 1'b0;
                vsync_in = 1'b0;
                tick();
                return;
            end
            send_line(1, blank);
        end
        vsync_in = 1'b1;
        tick();
        vsync_in = 1'b0;
        tick();
    endtask

    task automatic check_mode(input string tag, input int s, input int ew, input int el,
                              input int l224, input int npulse);
        check({tag, ".slot"}, slot, s);
        check({tag, ".exp_w"}, expected_width, ew);
        check({tag, ".exp_l"}, expected_lines, el);
        check({tag, ".l224"}, line_224, l224);
        check({tag, ".valid"}, mode_valid, 1);
        check({tag, ".pulses"}, pulses, npulse);
    endtask

    initial begin
        repeat (3) tick();
        check("rst.slot", slot, 0);
        check("rst.exp_w", expected_width, 256);
        check("rst.exp_l", expected_lines, 240);
        check("rst.l224", line_224, 0);
        check("rst.valid", mode_valid, 0);
        check("rst.change", mode_change, 0);
        check("rst.meas_w", measured_width, 0);
        check("rst.meas_l", measured_lines, 0);
        reset_n = 1'b1;
        tick();

        // First lock on 256 x 240.
        send_frame(256, 240);
        check("f1.meas_w", measured_width, 256);
        check("f1.meas_l", measured_lines, 240);
        check("f1.valid", mode_valid, 0);
        send_frame(256, 240);
        check("f2.valid", mode_valid, 0);
        send_frame(256, 240);
        check_mode("lock256", 0, 256, 240, 0, 1);
        check("lock256.change_low", mode_change, 0);

        // Interrupted candidate must not commit.
        send_frame(512, 224);
        send_frame(512, 224);
        send_frame(256, 240);
        check_mode("interrupt", 0, 256, 240, 0, 1);
        check("interrupt.meas_w", measured_width, 256);
        send_frame(512, 224);
        send_frame(512, 224);
        check("512x2.slot", slot, 0);
        send_frame(512, 224);
        check_mode("lock512", 2, 512, 224, 1, 2);

        // Width thresholds.
        repeat (3) send_frame(279, 224);
        check_mode("w279", 0, 256, 224, 1, 3);
        repeat (3) send_frame(280, 224);
        check_mode("w280", 1, 360, 224, 1, 4);
        repeat (3) send_frame(379, 224);
        check_mode("w379", 1, 360, 224, 1, 4);
        repeat (3) send_frame(380, 224);
        check_mode("w380", 2, 512, 224, 1, 5);

        // Line-count threshold.
        repeat (3) send_frame(380, 231);
        check("l231.meas_l", measured_lines, 231);
        check_mode("l231", 2, 512, 240, 0, 6);
        repeat (3) send_frame(380, 230);
        check_mode("l230", 2, 512, 224, 1, 7);

        // Coincident hsync/vsync on the last line.
        send_frame(256, 240, 1'b0, 1'b1);
        check("simul.meas_l", measured_lines, 240);
        check("simul.meas_w", measured_width, 256);
        check("simul.slot_held", slot, 2);

        // Asynchronous reset mid-frame while confirming.
        ce_pix = 1'b1;
        repeat (50) tick();
        reset_n = 1'b0;
        #1;
        check("arst.slot", slot, 0);
        check("arst.exp_w", expected_width, 256);
        check("arst.exp_l", expected_lines, 240);
        check("arst.l224", line_224, 0);
        check("arst.valid", mode_valid, 0);
        check("arst.meas_w", measured_width, 0);
        check("arst.meas_l", measured_lines, 0);
        ce_pix = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // Empty frames interleaved with good ones.
        send_frame(256, 240);
        check("e.g1.valid", mode_valid, 0);
        send_frame(256, 240, 1'b1);
        check("e.e1.meas_w", measured_width, 0);
        check("e.e1.meas_l", measured_lines, 0);
        check("e.e1.valid", mode_valid, 0);
        send_frame(256, 240);
        check("e.g2.valid", mode_valid, 0);
        send_frame(256, 240, 1'b1);
        check("e.e2.meas_w", measured_width, 0);
        send_frame(256, 240);
        check_mode("e.lock", 0, 256, 240, 0, 8);

        // Width saturation.
        send_frame(1100, 240);
        check("sat.meas_w", measured_width, 1023);
        send_frame(1100, 240);
        send_frame(1100, 240);
        check_mode("sat", 2, 512, 240, 0, 9);

`ifdef VIDEO_MODE_OVERRIDE_EN
        force_slot = 3'd1;
        force_224 = 1'b0;
        force_en = 1'b1;
        tick();
        check("force.slot", slot, 1);
        check("force.exp_w", expected_width, 360);
        tick();
        check("force.pulses", pulses, 10);
        force_en = 1'b0;
        tick();
        check("release.slot", slot, 2);
        check("release.exp_w", expected_width, 512);
        tick();
        check("release.pulses", pulses, 11);
`endif

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
